// File: rtl/wb_sdr_arbiter_if.sv
// Bus bundle between NUM_M Wishbone masters, the arbiter and the SDRAM controller slave port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wb_sdr_arbiter_if #(
  parameter int NUM_M  = 4,
  parameter int APP_AW = 26,
  parameter int DW     = 32
);
  // Master side
  logic [NUM_M-1:0]        m_cyc_i;
  logic [NUM_M-1:0]        m_stb_i;
  logic [NUM_M-1:0]        m_we_i;
  logic [NUM_M*DW/8-1:0]   m_sel_i;
  logic [NUM_M*APP_AW-1:0] m_addr_i;
  logic [NUM_M*DW-1:0]     m_dat_i;
  logic [DW-1:0]           m_dat_o;
  logic [NUM_M-1:0]        m_ack_o;
  logic [NUM_M-1:0]        m_err_o;

  // SDRAM controller side
  logic                    s_cyc_o;
  logic                    s_stb_o;
  logic                    s_we_o;
  logic [DW/8-1:0]         s_sel_o;
  logic [APP_AW-1:0]       s_addr_o;
  logic [DW-1:0]           s_dat_o;
  logic [DW-1:0]           s_dat_i;
  logic                    s_ack_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_addr_i, m_dat_i, s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_dat_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_addr_i, m_dat_i, s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_dat_o
  );
endinterface

// File: rtl/wb_sdr_arbiter.sv
// Round-robin Wishbone arbiter in front of the SDRAM controller slave port.
// Ownership lasts a whole cyc burst; a per-grant watchdog aborts accesses that are never acked.
module wb_sdr_arbiter #(
  parameter int NUM_M   = 4,
  parameter int APP_AW  = 26,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  wb_sdr_arbiter_if.slave     bus,
  output logic [NUM_M-1:0]    grant_o,
  output logic                busy_o
);

  localparam int SW   = DW / 8;
  localparam int IW   = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX   = {WD_W{1'b1}};
  localparam bit WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_gidx;
  logic [NUM_M-1:0]  r_grant;
  logic [WD_W-1:0]   r_wd;
  logic [WD_W-1:0]   w_wd_nxt;

  logic              w_win_vld;
  logic [IW-1:0]     w_win_idx;
  logic [IW-1:0]     w_cand;

  logic [NUM_M-1:0]  w_gsel;
  logic              w_own_cyc;
  logic              w_own_stb;
  logic              w_own_we;
  logic [SW-1:0]     w_own_sel;
  logic [APP_AW-1:0] w_own_addr;
  logic [DW-1:0]     w_own_dat;

  logic              w_s_cyc;
  logic              w_s_stb;
  logic              w_s_we;
  logic [SW-1:0]     w_s_sel;
  logic [APP_AW-1:0] w_s_addr;
  logic [DW-1:0]     w_s_dat;
  logic [NUM_M-1:0]  w_ack;
  logic [NUM_M-1:0]  w_err;

  // Round-robin search: first cyc requester strictly after the last winner, wrapping.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = r_ptr;
    w_cand    = '0;
    for (int k = 1; k <= NUM_M; k++) begin
      w_cand = IW'((int'(r_ptr) + k) % NUM_M);
      for (int i = 0; i < NUM_M; i++) begin
        if (!w_win_vld && (w_cand == IW'(i)) && bus.m_cyc_i[i]) begin
          w_win_vld = 1'b1;
          w_win_idx = w_cand;
        end
      end
    end
  end

  // Select the granted master's request signals.
  always_comb begin
    w_gsel     = '0;
    w_own_cyc  = 1'b0;
    w_own_stb  = 1'b0;
    w_own_we   = 1'b0;
    w_own_sel  = '0;
    w_own_addr = '0;
    w_own_dat  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (r_gidx == IW'(i)) begin
        w_gsel[i]  = 1'b1;
        w_own_cyc  = bus.m_cyc_i[i];
        w_own_stb  = bus.m_stb_i[i];
        w_own_we   = bus.m_we_i[i];
        w_own_sel  = bus.m_sel_i[i*SW +: SW];
        w_own_addr = bus.m_addr_i[i*APP_AW +: APP_AW];
        w_own_dat  = bus.m_dat_i[i*DW +: DW];
      end
    end
  end

  // Next state, watchdog and bus outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_wd_nxt    = r_wd;
    w_s_cyc     = 1'b0;
    w_s_stb     = 1'b0;
    w_s_we      = 1'b0;
    w_s_sel     = '0;
    w_s_addr    = '0;
    w_s_dat     = '0;
    w_ack       = '0;
    w_err       = '0;
    case (r_state)
      ST_IDLE: begin
        w_wd_nxt = '0;
        if (w_win_vld) begin
          w_state_nxt = ST_OWN;
        end
      end
      ST_OWN: begin
        w_s_cyc  = w_own_cyc;
        w_s_stb  = w_own_stb;
        w_s_we   = w_own_we;
        w_s_sel  = w_own_sel;
        w_s_addr = w_own_addr;
        w_s_dat  = w_own_dat;
        w_ack    = w_gsel & {NUM_M{bus.s_ack_i}};
        // Releasing cyc takes priority over a timeout firing in the same cycle.
        if (!w_own_cyc) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.s_ack_i) begin
          w_wd_nxt = '0;
        end else if (WD_EN && (r_wd == WD_LIMIT)) begin
          w_err       = w_gsel;
          w_state_nxt = ST_ABORT;
        end else if (w_own_stb && (r_wd != WD_MAX)) begin
          w_wd_nxt = r_wd + 1'b1;
        end
      end
      ST_ABORT: begin
        w_wd_nxt = '0;
        if (!w_own_cyc) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_wd_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_ptr   <= IW'(NUM_M - 1);
      r_gidx  <= '0;
      r_grant <= '0;
      r_wd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wd    <= w_wd_nxt;
      if ((r_state == ST_IDLE) && w_win_vld) begin
        r_gidx  <= w_win_idx;
        r_ptr   <= w_win_idx;
        r_grant <= NUM_M'(1) << w_win_idx;
      end else if (w_state_nxt == ST_IDLE) begin
        r_grant <= '0;
      end
    end
  end

  assign bus.s_cyc_o  = w_s_cyc;
  assign bus.s_stb_o  = w_s_stb;
  assign bus.s_we_o   = w_s_we;
  assign bus.s_sel_o  = w_s_sel;
  assign bus.s_addr_o = w_s_addr;
  assign bus.s_dat_o  = w_s_dat;
  assign bus.m_ack_o  = w_ack;
  assign bus.m_err_o  = w_err;
  assign bus.m_dat_o  = bus.s_dat_i;
  assign grant_o      = r_grant;
  assign busy_o       = (r_state != ST_IDLE);

endmodule
